// File: rtl/alu_control_decoder.sv
// MIPS decode stage: instruction + register values -> ALUControl, operands and qualifiers,
// held in a 2-entry valid/ready output buffer. Define ALU_DEC_MUL_EN to decode mul.
module alu_control_decoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic        InValid,
    output logic        InReady,
    input  logic        Flush,
    output logic [3:0]  ALUControl,
    output logic [31:0] OpA,
    output logic [31:0] OpB,
    output logic [4:0]  WriteReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Illegal,
    output logic        OutValid,
    input  logic        OutReady
);

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  wreg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
    } dec_t;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext;
    logic        unused_rs_field;
    logic        bad;
    dec_t        dec;

    assign opcode   = Instr[31:26];
    assign rt       = Instr[20:16];
    assign rd       = Instr[15:11];
    assign shamt    = Instr[10:6];
    assign funct    = Instr[5:0];
    assign imm_sext = {{16{Instr[15]}}, Instr[15:0]};
    assign imm_zext = {16'b0, Instr[15:0]};
    // The rs index only selects RsData upstream; the value arrives on RsData.
    assign unused_rs_field = ^Instr[25:21];

    always_comb begin
        dec = '0;
        bad = 1'b0;
        unique case (opcode)
            6'h00: begin
                dec.op_a      = RsData;
                dec.op_b      = RtData;
                dec.wreg      = rd;
                dec.reg_write = 1'b1;
                unique case (funct)
                    6'h20, 6'h21: dec.alu = 4'b0000;
                    6'h22, 6'h23: dec.alu = 4'b0001;
                    6'h24:        dec.alu = 4'b1000;
                    6'h25:        dec.alu = 4'b1001;
                    6'h27:        dec.alu = 4'b1010;
                    6'h26:        dec.alu = 4'b1011;
                    6'h2A:        dec.alu = 4'b1110;
                    6'h00, 6'h02: begin
                        dec.alu  = (funct == 6'h00) ? 4'b1100 : 4'b1101;
                        dec.op_a = RtData;
                        dec.op_b = {27'b0, shamt};
                    end
                    default:      bad = 1'b1;
                endcase
            end
            6'h1C: begin
`ifdef ALU_DEC_MUL_EN
                dec.alu       = 4'b0010;
                dec.op_a      = RsData;
                dec.op_b      = RtData;
                dec.wreg      = rd;
                dec.reg_write = 1'b1;
                bad           = (funct != 6'h02);
`else
                bad = 1'b1;
`endif
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                dec.op_a      = RsData;
                dec.wreg      = rt;
                dec.reg_write = 1'b1;
                unique case (opcode)
                    6'h0A:   begin dec.alu = 4'b1110; dec.op_b = imm_sext; end
                    6'h0C:   begin dec.alu = 4'b1000; dec.op_b = imm_zext; end
                    6'h0D:   begin dec.alu = 4'b1001; dec.op_b = imm_zext; end
                    6'h0E:   begin dec.alu = 4'b1011; dec.op_b = imm_zext; end
                    default: begin dec.alu = 4'b0000; dec.op_b = imm_sext; end
                endcase
            end
            6'h23: begin
                dec.op_a      = RsData;
                dec.op_b      = imm_sext;
                dec.wreg      = rt;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            6'h2B: begin
                dec.op_a      = RsData;
                dec.op_b      = imm_sext;
                dec.mem_write = 1'b1;
            end
            6'h04, 6'h05: begin
                dec.alu    = 4'b0001;
                dec.op_a   = RsData;
                dec.op_b   = RtData;
                dec.branch = 1'b1;
            end
            6'h01: begin
                dec.alu    = 4'b0011;
                dec.op_a   = RsData;
                dec.op_b   = {31'b0, rt[0]};
                dec.branch = 1'b1;
                bad        = (rt[4:1] != 4'b0);
            end
            6'h06, 6'h07: begin
                dec.alu    = (opcode == 6'h07) ? 4'b0100 : 4'b0101;
                dec.op_a   = RsData;
                dec.branch = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.alu     = 4'b1111;
            dec.illegal = 1'b1;
        end
    end

    // slot0 is always the head; slot1 only holds data at count 2.
    dec_t       slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       rdy_q;
    logic       push, pop;

    assign InReady  = rdy_q && (count_q != 2'd2);
    assign OutValid = (count_q != 2'd0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (Flush) begin
            count_d = 2'd0;
        end else if (push && pop) begin
            slot0_d = dec;
        end else if (push) begin
            if (count_q == 2'd0) slot0_d = dec;
            else                 slot1_d = dec;
            count_d = count_q + 2'd1;
        end else if (pop) begin
            if (count_q == 2'd2) slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
            rdy_q   <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            rdy_q   <= 1'b1;
        end
    end

    assign ALUControl = slot0_q.alu;
    assign OpA        = slot0_q.op_a;
    assign OpB        = slot0_q.op_b;
    assign WriteReg   = slot0_q.wreg;
    assign RegWrite   = slot0_q.reg_write;
    assign MemRead    = slot0_q.mem_read;
    assign MemWrite   = slot0_q.mem_write;
    assign Branch     = slot0_q.branch;
    assign Illegal    = slot0_q.illegal;

endmodule
